// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder and its arbiter.
package adder_pkg;

  // Core latency in clock edges; the arbiter's tag pipeline depth must match it.
  localparam int unsigned ADDER_LAT = 3;

  // Ceiling log2 with a floor of 1 so that a 2-entry index still gets a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) begin
        r = i + 1;
      end
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pipelined_adder_core.sv
// Three-stage carry-select adder: register inputs, per-block speculative sums, carry select.
module pipelined_adder_core
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 8
) (
  input  logic             clk,
  input  logic             v_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             v_out,
  output logic [WIDTH-1:0] sum
);

  localparam int unsigned NB = WIDTH / BLOCK;

  // Stage 1: captured operands.
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin1_q, v1_q;

  // Stage 2: each block summed assuming carry-in 0 and carry-in 1.
  logic [WIDTH-1:0] s0_d, s1_d, s0_q, s1_q;
  logic [NB-1:0]    c0_d, c1_d, c0_q, c1_q;
  logic             cin2_q, v2_q;

  // Stage 3: resolved sum.
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             v3_q;
  logic             carry;

  always_comb begin
    s0_d = '0;
    s1_d = '0;
    c0_d = '0;
    c1_d = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      {c0_d[k], s0_d[k*BLOCK +: BLOCK]} = {1'b0, a_q[k*BLOCK +: BLOCK]}
                                        + {1'b0, b_q[k*BLOCK +: BLOCK]};
      {c1_d[k], s1_d[k*BLOCK +: BLOCK]} = {1'b0, a_q[k*BLOCK +: BLOCK]}
                                        + {1'b0, b_q[k*BLOCK +: BLOCK]}
                                        + (BLOCK+1)'(1);
    end
  end

  // Ripple only the block carries through the precomputed select muxes.
  always_comb begin
    sum_d = '0;
    carry = cin2_q;
    for (int unsigned k = 0; k < NB; k++) begin
      sum_d[k*BLOCK +: BLOCK] = carry ? s1_q[k*BLOCK +: BLOCK] : s0_q[k*BLOCK +: BLOCK];
      carry                   = carry ? c1_q[k] : c0_q[k];
    end
  end

  always_ff @(posedge clk) begin
    a_q    <= a;
    b_q    <= b;
    cin1_q <= cin;
    v1_q   <= v_in;
    s0_q   <= s0_d;
    s1_q   <= s1_d;
    c0_q   <= c0_d;
    c1_q   <= c1_d;
    cin2_q <= cin1_q;
    v2_q   <= v1_q;
    sum_q  <= sum_d;
    v3_q   <= v2_q;
  end

  assign sum   = sum_q;
  assign v_out = v3_q;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter
  import adder_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (en && !found && req[IW'(idx)]) begin
        found             = 1'b1;
        gnt[IW'(idx)]     = 1'b1;
        gnt_idx           = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin front end sharing one pipelined adder among NREQ requesters;
// a tag pipeline matched to the core latency returns each sum with its owner's index.
module adder_arbiter
  import adder_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned BLOCK = 8,
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned IDW   = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic                  hold,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  idle
);

  localparam int unsigned LAT = ADDER_LAT;

  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             arb_en;
  logic             xfer;

  logic [LAT-1:0]   tag_vld_q, tag_vld_d;
  logic [IDW-1:0]   tag_id_q [LAT];
  logic [IDW-1:0]   tag_id_d [LAT];

  logic [WIDTH-1:0] core_a, core_b, core_sum;
  logic             core_cin, core_v_out;

  // Gating the arbiter itself keeps ready low in reset and under hold.
  assign arb_en = ~hold & ~rst;

  rr_arbiter #(
    .N(NREQ)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |(req_valid & gnt);

  always_comb begin
    core_a   = '0;
    core_b   = '0;
    core_cin = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        core_a   = req_a[i*WIDTH +: WIDTH];
        core_b   = req_b[i*WIDTH +: WIDTH];
        core_cin = req_cin[i];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    tag_vld_d    = {tag_vld_q[LAT-2:0], xfer};
    tag_id_d[0]  = gnt_idx;
    for (int unsigned s = 1; s < LAT; s++) begin
      tag_id_d[s] = tag_id_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      tag_vld_q <= '0;
      for (int unsigned s = 0; s < LAT; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      tag_vld_q <= tag_vld_d;
      for (int unsigned s = 0; s < LAT; s++) begin
        tag_id_q[s] <= tag_id_d[s];
      end
    end
  end

  // The core has no reset, so only the tag pipeline decides result validity.
  pipelined_adder_core #(
    .WIDTH(WIDTH),
    .BLOCK(BLOCK)
  ) u_core (
    .clk  (clk),
    .v_in (xfer),
    .a    (core_a),
    .b    (core_b),
    .cin  (core_cin),
    .v_out(core_v_out),
    .sum  (core_sum)
  );

  assign rsp_valid = tag_vld_q[LAT-1];
  assign rsp_id    = tag_id_q[LAT-1];
  assign rsp_sum   = core_sum;
  assign idle      = ~|tag_vld_q;

  rsp_valid_has_core_result: assert property (
    @(posedge clk) disable iff (rst) rsp_valid |-> core_v_out
  );

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed-vector and model-checked bench for the round-robin adder arbiter.
module tb_adder_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned BLOCK = 8;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = 2;
  localparam int unsigned LAT   = 3;
  localparam int unsigned NVEC  = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  hold;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  idle;

  adder_arbiter #(
    .WIDTH(WIDTH),
    .BLOCK(BLOCK),
    .NREQ (NREQ)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_cin  (req_cin),
    .hold     (hold),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_sum  (rsp_sum),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         r;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
  } vec_t;

  vec_t vecs[NVEC];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int               ptr_m;
  logic             mv   [LAT];
  logic [IDW-1:0]   mid  [LAT];
  logic [WIDTH-1:0] msum [LAT];
  int               wait_m [NREQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic cin);
    req_a[r*WIDTH +: WIDTH] = a;
    req_b[r*WIDTH +: WIDTH] = b;
    req_cin[r]              = cin;
  endtask

  // One clock: check ready against the model, clock, then check response outputs.
  task automatic step(output int gi);
    logic [NREQ-1:0]  g;
    logic [WIDTH-1:0] s;
    logic             any;
    g  = '0;
    gi = -1;
    s  = '0;
    if (!hold && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (ptr_m + k) % NREQ;
        if (gi < 0 && req_valid[j]) gi = j;
      end
    end
    if (gi >= 0) begin
      g[gi] = 1'b1;
      s = req_a[gi*WIDTH +: WIDTH] + req_b[gi*WIDTH +: WIDTH] + WIDTH'(req_cin[gi]);
    end
    #1;
    check("req_ready", 64'(req_ready), 64'(g));
    for (int j = 0; j < NREQ; j++) begin
      if (gi == j || !req_valid[j]) wait_m[j] = 0;
      else if (!hold && !rst) wait_m[j]++;
      if (req_valid[j]) check("fair_wait", 64'(wait_m[j] < NREQ), 64'(1));
    end
    @(posedge clk);
    for (int st = LAT - 1; st > 0; st--) begin
      mv[st]   = mv[st-1];
      mid[st]  = mid[st-1];
      msum[st] = msum[st-1];
    end
    mv[0]   = (gi >= 0);
    mid[0]  = (gi >= 0) ? IDW'(gi) : '0;
    msum[0] = s;
    if (gi >= 0) ptr_m = (gi + 1) % NREQ;
    if (rst) begin
      for (int st = 0; st < LAT; st++) mv[st] = 1'b0;
      ptr_m = 0;
    end
    @(negedge clk);
    check("rsp_valid", 64'(rsp_valid), 64'(mv[LAT-1]));
    if (mv[LAT-1]) begin
      check("rsp_id", 64'(rsp_id), 64'(mid[LAT-1]));
      check("rsp_sum", 64'(rsp_sum), 64'(msum[LAT-1]));
    end
    any = 1'b0;
    for (int st = 0; st < LAT; st++) any = any | mv[st];
    check("idle", 64'(idle), 64'(!any));
  endtask

  initial begin
    int gi;
    logic [NREQ-1:0] exp_rdy;

    vecs[0] = '{2, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100};
    vecs[1] = '{0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[2] = '{1, 32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0001};
    vecs[3] = '{3, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789};
    vecs[4] = '{2, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001};
    vecs[5] = '{1, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100};
    vecs[6] = '{0, 32'h00FF_FFFF, 32'h0000_0000, 1'b1, 32'h0100_0000};
    vecs[7] = '{3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF};

    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    ptr_m     = 0;
    for (int st = 0; st < LAT; st++) begin
      mv[st] = 1'b0; mid[st] = '0; msum[st] = '0;
    end
    for (int j = 0; j < NREQ; j++) wait_m[j] = 0;

    // Reset state.
    step(gi);
    step(gi);
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_id", 64'(rsp_id), 64'(0));
    check("reset_idle", 64'(idle), 64'(1));
    req_valid = '1;
    #1;
    check("reset_ready", 64'(req_ready), 64'(0));
    req_valid = '0;
    rst = 1'b0;

    // Directed single-op vectors with fixed 3-cycle latency.
    for (int v = 0; v < NVEC; v++) begin
      set_op(vecs[v].r, vecs[v].a, vecs[v].b, vecs[v].cin);
      req_valid[vecs[v].r] = 1'b1;
      exp_rdy = '0;
      exp_rdy[vecs[v].r] = 1'b1;
      #1;
      check("vec_ready", 64'(req_ready), 64'(exp_rdy));
      step(gi);
      req_valid = '0;
      step(gi);
      check("vec_early", 64'(rsp_valid), 64'(0));
      step(gi);
      check("vec_valid", 64'(rsp_valid), 64'(1));
      check("vec_id", 64'(rsp_id), 64'(vecs[v].r));
      check("vec_sum", 64'(rsp_sum), 64'(vecs[v].sum));
      step(gi);
      check("vec_idle", 64'(idle), 64'(1));
    end

    // All requesters valid for 8 cycles after reset: strict rotation, gapless responses.
    rst = 1'b1;
    step(gi);
    rst = 1'b0;
    for (int r = 0; r < NREQ; r++) set_op(r, $urandom, $urandom, 1'($urandom));
    req_valid = '1;
    for (int s = 0; s < 11; s++) begin
      if (s == 8) req_valid = '0;
      exp_rdy = (s < 8) ? NREQ'(1 << (s % 4)) : '0;
      #1;
      check("rr_ready", 64'(req_ready), 64'(exp_rdy));
      step(gi);
      if (s >= 2 && s < 10) begin
        check("rr_rsp_valid", 64'(rsp_valid), 64'(1));
        check("rr_rsp_id", 64'(rsp_id), 64'((s - 2) % 4));
      end else begin
        check("rr_rsp_valid", 64'(rsp_valid), 64'(0));
      end
    end

    // Hold with requests pending: no grants, drain, then resume from saved pointer.
    req_valid = '1;
    step(gi);
    step(gi);
    hold = 1'b1;
    for (int h = 0; h < 4; h++) begin
      #1;
      check("hold_ready", 64'(req_ready), 64'(0));
      step(gi);
      check("hold_idle", 64'(idle), 64'(h >= 2));
      if (h < 2) check("hold_drain_id", 64'(rsp_id), 64'(h));
    end
    hold = 1'b0;
    #1;
    check("resume_ready", 64'(req_ready), 64'(4'b0100));
    step(gi);
    req_valid = '0;
    for (int d = 0; d < 4; d++) step(gi);

    // Reset one cycle after two accepts drops both ops and restarts the pointer.
    req_valid = 4'b0011;
    step(gi);
    step(gi);
    req_valid = '0;
    rst = 1'b1;
    step(gi);
    rst = 1'b0;
    check("rst_drop_valid", 64'(rsp_valid), 64'(0));
    check("rst_idle", 64'(idle), 64'(1));
    req_valid = 4'b1010;
    #1;
    check("rst_first_grant", 64'(req_ready), 64'(4'b0010));
    step(gi);
    req_valid[1] = 1'b0;
    step(gi);
    check("rst_no_stale", 64'(rsp_valid), 64'(0));
    step(gi);
    check("rst_new_rsp", 64'(rsp_valid), 64'(1));
    check("rst_new_id", 64'(rsp_id), 64'(1));
    req_valid = '0;
    for (int d = 0; d < 4; d++) step(gi);

    // Randomised traffic against the reference model.
    for (int c = 0; c < 10000; c++) begin
      hold = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < NREQ; j++) begin
        if (!req_valid[j] && $urandom_range(0, 2) == 0) begin
          set_op(j, $urandom, $urandom, 1'($urandom));
          req_valid[j] = 1'b1;
        end
      end
      step(gi);
      if (gi >= 0) req_valid[gi] = 1'b0;
    end
    hold      = 1'b0;
    req_valid = '0;
    for (int d = 0; d < 4; d++) step(gi);
    check("final_idle", 64'(idle), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin scheduler that shares one `pipelined_adder_core` among `NREQ` requesters. It accepts at most one add per cycle through per-requester valid/ready handshakes and issues it to the core. A tag pipeline matched to the core latency tracks each operation and returns every result with the originating requester index. It sits between the ALU front-end clients and the single adder instance.

## Interface
- `WIDTH`, 32: operand and sum width; must be a multiple of `BLOCK`.
- `BLOCK`, 8: carry-select block width, passed to the core.
- `NREQ`, 4: number of requesters, 2..16.
- `IDW`, clog2(`NREQ`): requester-id width, derived and not overridden.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester operation valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit set.
- `req_a`  in  NREQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand B, same slicing.
- `req_cin`  in  NREQ  carry-in per requester.
- `hold`  in  1  when high, no new grants; in-flight operations still complete.
- `rsp_valid`  out  1  result valid, one-cycle pulse per operation.
- `rsp_id`  out  IDW  index of the requester that owns the result.
- `rsp_sum`  out  WIDTH  sum, taken directly from the core.
- `idle`  out  1  high when no operation is in flight.

## Operation
- Arbitration is combinational round-robin over `req_valid`, starting at `rr_ptr`.
- `req_ready[i]` = grant[i] & ~`hold` & ~`rst`. Ready may depend on valid. A requester must not make its valid depend on ready.
- Handshake: transfer occurs when `req_valid[i]` & `req_ready[i]` at an edge. Operands must be stable while valid is high and unaccepted.
- On transfer:
  - the granted requester's operands and cin are muxed onto core `a`/`b`/`cin` and `v_in` is high;
  - `rr_ptr` advances to (granted index + 1) mod `NREQ`.
- With no transfer, `v_in` is low and `rr_ptr` holds.
- Fairness: a requester holding valid high is granted within `NREQ` cycles in which `hold` is low.
- Tag pipeline: `LAT` = 3 stages of {valid, id}. Stage 0 is loaded on transfer; otherwise its valid bit is loaded with 0. The pipeline shifts every cycle.
- Outputs from the final tag stage: `rsp_valid` = final valid, `rsp_id` = final id. `rsp_sum` is the core `sum`.
- The core `v_out` is not used for `rsp_valid`, because the core has no reset. Assertion in verification: `rsp_valid` implies core `v_out`.
- `rsp_sum` = (a + b + cin) mod 2^WIDTH; carry-out is discarded.
- Responses have no backpressure; every requester must accept its response in the cycle it appears.
- `idle` = no tag-stage valid bit set.

## Timing
- Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `idle` = 1, `rr_ptr` = 0, all tag stages invalid, core `v_in` = 0. `rsp_sum` is don't-care while `rsp_valid` is low.
- Latency: a transfer at edge T produces `rsp_valid` high in the cycle following edge T+2, i.e. the 3rd cycle after the accept cycle. Throughput is one result per cycle.
- Back-to-back transfers from different requesters produce consecutive responses in grant order.
- Reset mid-operation: all in-flight tags are dropped and `rsp_valid` is low from the cycle after the reset edge. Stale core outputs are masked because the tags are invalid.
- `hold` rising: grants stop in the same cycle (ready is combinational). Outstanding results still emerge. `idle` rises 3 cycles after the last transfer.
- Simultaneous `hold` and valid: no transfer, and `rr_ptr` does not move.

## Structure
- Package `adder_pkg`:
  - `ADDER_LAT` = 3, the core latency constant shared with the core's users;
  - clog2 function for `IDW`.
- One sub-module, `rr_arbiter` (parameter `N`): inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and encoded `gnt_idx`. It is purely combinational; `rr_ptr` lives in the parent.
- The parent instantiates `pipelined_adder_core` with `WIDTH`/`BLOCK`.

## Test plan
- Single op: requester 2 with a=0x0000_00FF, b=0x0000_0001, cin=0 accepted in cycle 5 -> `rsp_valid` in cycle 8, `rsp_id`=2, `rsp_sum`=0x0000_0100.
- Wrap with carry-in: a=0xFFFF_FFFF, b=0, cin=1 -> `rsp_sum`=0x0000_0000. a=0x0000_FFFF, b=0x0000_0001, cin=1 -> 0x0001_0001.
- All four requesters valid continuously for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3. Responses arrive 3 cycles later with the same id order and no gaps.
- `hold` high for 4 cycles with requests pending -> `req_ready` = 0 throughout and in-flight results drain. `idle` rises 3 cycles after the last accept. Granting resumes from the saved `rr_ptr`.
- `rst` pulsed 1 cycle after two accepts -> no `rsp_valid` for those ops. After reset, `idle` = 1 and `rr_ptr` = 0. The first accept goes to the lowest valid index.
- Randomized valid/hold for 10k cycles vs. a reference model:
  - every accepted op gets exactly one correct response;
  - no requester waits more than `NREQ` unheld cycles.
